// File: rtl/ro_freq_counter.sv
// Ring-oscillator tap frequency counter: selects one oscillator tap, synchronizes it,
// and counts its rising edges over a programmable gate window of system-clock cycles.
module ro_freq_counter #(
  parameter int GATE_W     = 16,
  parameter int CNT_W      = 24,
  parameter int SETTLE_CYC = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start,
  input  logic              abort,
  input  logic [4:0]        cfg_sel,
  input  logic [2:0]        tap_sel,
  input  logic [GATE_W-1:0] gate_len,
  input  logic [4:0]        ro_tap,
  output logic [4:0]        osc_sel,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              err
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state_r;
  logic [4:0]        sync1_r;
  logic [4:0]        sync2_r;
  logic              sel_r;
  logic              prev_r;
  logic [2:0]        tap_r;
  logic [GATE_W-1:0] gate_r;
  logic [TMR_W-1:0]  timer_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              ovf_r;

  logic              tap_mux_s;
  logic              edge_s;
  logic              last_s;
  logic [CNT_W-1:0]  cnt_next_s;
  logic              ovf_next_s;

  // Two-flop synchronizers on every tap, then one more stage on the selected tap
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1_r <= 5'b00000;
      sync2_r <= 5'b00000;
      sel_r   <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= ro_tap;
      sync2_r <= sync1_r;
      sel_r   <= tap_mux_s;
      prev_r  <= sel_r;
    end
  end

  // Tap selection; out-of-range selects read as a quiet tap
  always_comb begin
    tap_mux_s = 1'b0;
    case (tap_r)
      3'd0:    tap_mux_s = sync2_r[0];
      3'd1:    tap_mux_s = sync2_r[1];
      3'd2:    tap_mux_s = sync2_r[2];
      3'd3:    tap_mux_s = sync2_r[3];
      3'd4:    tap_mux_s = sync2_r[4];
      default: tap_mux_s = 1'b0;
    endcase
  end

  assign edge_s = sel_r & ~prev_r;

  // Saturating edge counter and end-of-window detect
  always_comb begin
    cnt_next_s = cnt_r;
    ovf_next_s = ovf_r;
    if (edge_s) begin
      if (cnt_r == CNT_MAX) begin
        ovf_next_s = 1'b1;
      end else begin
        cnt_next_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_next_s = cnt_r;
      ovf_next_s = ovf_r;
    end
    last_s = (timer_r == (TMR_W'(gate_r) - TMR_ONE));
  end

  // Measurement sequencer; result outputs only change when a measurement completes
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r  <= IDLE;
      tap_r    <= 3'd0;
      gate_r   <= {GATE_W{1'b0}};
      timer_r  <= {TMR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      ovf_r    <= 1'b0;
      osc_sel  <= 5'b00000;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= {CNT_W{1'b0}};
      overflow <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            osc_sel <= cfg_sel;
            tap_r   <= tap_sel;
            gate_r  <= gate_len;
            cnt_r   <= {CNT_W{1'b0}};
            ovf_r   <= 1'b0;
            timer_r <= {TMR_W{1'b0}};
            busy    <= 1'b1;
            if (tap_sel > 3'd4) begin
              state_r  <= DONE;
              done     <= 1'b1;
              count    <= {CNT_W{1'b0}};
              overflow <= 1'b0;
              err      <= 1'b1;
            end else begin
              state_r <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (abort) begin
            state_r <= IDLE;
            osc_sel <= 5'b00000;
            busy    <= 1'b0;
          end else if (timer_r == SETTLE_LAST) begin
            timer_r <= {TMR_W{1'b0}};
            if (gate_r == {GATE_W{1'b0}}) begin
              state_r  <= DONE;
              done     <= 1'b1;
              count    <= {CNT_W{1'b0}};
              overflow <= 1'b0;
              err      <= 1'b0;
            end else begin
              state_r <= MEASURE;
            end
          end else begin
            timer_r <= timer_r + TMR_ONE;
          end
        end
        MEASURE: begin
          if (abort) begin
            state_r <= IDLE;
            osc_sel <= 5'b00000;
            busy    <= 1'b0;
          end else begin
            cnt_r <= cnt_next_s;
            ovf_r <= ovf_next_s;
            if (last_s) begin
              state_r  <= DONE;
              done     <= 1'b1;
              count    <= cnt_next_s;
              overflow <= ovf_next_s;
              err      <= 1'b0;
            end else begin
              timer_r <= timer_r + TMR_ONE;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          osc_sel <= 5'b00000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Randomized bench for ro_freq_counter: tap history is recorded per cycle and
// expected counts are derived from it with the 3-cycle detect latency and gate window.
module tb_ro_freq_counter;
  localparam int S = 16;
  localparam int N = 8192;

  logic        clk, rst, start, abort;
  logic [4:0]  cfg_sel, ro_tap;
  logic [2:0]  tap_sel;
  logic [15:0] gate_len;
  logic [4:0]  osc_sel, osc_sel4;
  logic        busy, done, overflow, err;
  logic        busy4, done4, overflow4, err4;
  logic [23:0] count;
  logic [3:0]  count4;

  int checks = 0, failures = 0;
  int gcyc = 0, tap_mode = 0;
  logic [4:0] hist [N];
  logic [31:0] last_cnt = 0, last_ovf = 0, last_err = 0;
  logic [3:0] c4;
  logic o4;

  ro_freq_counter dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .abort(abort),
    .cfg_sel(cfg_sel), .tap_sel(tap_sel), .gate_len(gate_len), .ro_tap(ro_tap),
    .osc_sel(osc_sel), .busy(busy), .done(done), .count(count),
    .overflow(overflow), .err(err));

  ro_freq_counter #(.CNT_W(4)) dut4 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .abort(abort),
    .cfg_sel(cfg_sel), .tap_sel(tap_sel), .gate_len(gate_len), .ro_tap(ro_tap),
    .osc_sel(osc_sel4), .busy(busy4), .done(done4), .count(count4),
    .overflow(overflow4), .err(err4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance one clock; sample point is 1ns after the edge, then drive a new tap value
  task automatic step();
    @(posedge clk);
    #1;
    gcyc++;
    case (tap_mode)
      1:       ro_tap = ((gcyc >> 1) & 1) != 0 ? 5'h1f : 5'h00;
      2:       ro_tap = (gcyc & 1) != 0 ? 5'h1f : 5'h00;
      default: ro_tap = 5'($urandom);
    endcase
    hist[gcyc % N] = ro_tap;
  endtask

  // rising edges whose detect pulse (3 cycles after the tap change) lands in the window
  function automatic int model_edges(int t0, int tsel, int gl);
    int n = 0;
    for (int c = t0 + S + 1; c <= t0 + S + gl; c++) begin
      int k = c - 3;
      logic [4:0] a = hist[k % N];
      logic [4:0] b = hist[(k - 1) % N];
      if (a[tsel] && !b[tsel]) n++;
    end
    return n;
  endfunction

  task automatic run_meas(input logic [2:0] tsel, input logic [4:0] cfg, input logic [15:0] gl,
                          input int mode, input logic abt);
    int t0, dcyc, lim, exp_d, e;
    tap_mode = mode;
    start = 1'b1; abort = abt; cfg_sel = cfg; tap_sel = tsel; gate_len = gl;
    t0 = gcyc;
    dcyc = -1;
    lim = S + int'(gl) + 8;
    for (int i = 1; i <= lim; i++) begin
      step();
      if (i == 1) begin
        start = 1'b0; abort = 1'b0;
        chk("busy_c1", 32'(busy), 32'd1);
        if (tsel <= 3'd4) chk("osc_sel_c1", 32'(osc_sel), 32'(cfg));
      end
      if (done) begin
        dcyc = i; c4 = count4; o4 = overflow4;
        break;
      end
    end
    exp_d = (tsel > 3'd4) ? 1 : (gl == 16'd0) ? S + 1 : S + int'(gl) + 1;
    chk("done_cycle", 32'(dcyc), 32'(exp_d));
    if (dcyc >= 0) begin
      e = (tsel > 3'd4) ? 0 : model_edges(t0, int'(tsel), int'(gl));
      last_cnt = 32'(e);
      last_ovf = 32'd0;
      last_err = (tsel > 3'd4) ? 32'd1 : 32'd0;
      chk("count", 32'(count), last_cnt);
      chk("overflow", 32'(overflow), last_ovf);
      chk("err", 32'(err), last_err);
      step();
      chk("busy_after", 32'(busy), 32'd0);
      chk("done_after", 32'(done), 32'd0);
      chk("osc_hold", 32'(osc_sel), 32'(cfg));
    end
  endtask

  initial begin
    int e, saw;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_sel = 5'd0; tap_sel = 3'd0;
    gate_len = 16'd0; ro_tap = 5'd0; hist[0] = 5'd0;
    for (int i = 0; i < 3; i++) step();
    chk("rst_osc_sel", 32'(osc_sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();

    run_meas(3'd2, 5'b10101, 16'd100, 1, 1'b0);
    chk("period4_count", 32'(count), 32'd25);

    run_meas(3'd2, 5'b00111, 16'd40, 2, 1'b0);
    e = model_edges(gcyc - 1 - (S + 41), 2, 40);
    chk("sat_count4", 32'(c4), (e > 15) ? 32'd15 : 32'(e));
    chk("sat_ovf4", 32'(o4), (e > 15) ? 32'd1 : 32'd0);
    chk("sat_count4_fixed", 32'(c4), 32'd15);

    run_meas(3'd6, 5'b11000, 16'd50, 0, 1'b0);
    run_meas(3'd1, 5'b00011, 16'd0, 0, 1'b0);
    run_meas(3'd4, 5'b01110, 16'd30, 0, 1'b1);

    for (int r = 0; r < 6; r++)
      run_meas(3'($urandom_range(0, 4)), 5'($urandom), 16'($urandom_range(1, 150)), 0, 1'b0);

    // abort mid-MEASURE with an ignored start while busy
    tap_mode = 0; saw = 0;
    start = 1'b1; cfg_sel = 5'b10110; tap_sel = 3'd3; gate_len = 16'd100;
    for (int i = 1; i <= 51; i++) begin
      step();
      start = 1'b0;
      abort = 1'b0;
      if (i == 10) begin start = 1'b1; tap_sel = 3'd7; end
      if (done) saw = 1;
      if (i == 50) abort = 1'b1;
    end
    chk("abort_osc_sel", 32'(osc_sel), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_count", 32'(count), last_cnt);
    chk("abort_overflow", 32'(overflow), last_ovf);
    chk("abort_err", 32'(err), last_err);
    for (int i = 0; i < 120; i++) begin
      step();
      if (done) saw = 1;
    end
    chk("abort_no_done", 32'(saw), 32'd0);

    // asynchronous reset in the middle of a measurement
    start = 1'b1; cfg_sel = 5'b11111; tap_sel = 3'd1; gate_len = 16'd100;
    for (int i = 1; i <= 60; i++) begin
      step();
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_osc_sel", 32'(osc_sel), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_overflow", 32'(overflow), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    run_meas(3'd0, 5'b01001, 16'd60, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
